// File: rtl/cache_control_if.sv
// Bundle of every controller-facing signal: the CPU request handshake,
// the datapath array controls and the physical memory handshake.
// The controller connects through the slave modport. The master modport
// is for the environment that drives the requests and datapath status.
//
// CPU handshake (valid/ready): the CPU raises mem_read or mem_write and
// holds it, with its address and data, until the cycle in which mem_resp
// is high. The access completes in that cycle. The memory side uses the
// same rule: pmem_read or pmem_write stays high until the cycle in which
// pmem_resp is high.
interface cache_control_if;
    // CPU side
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    // datapath status at the current index
    logic hit;
    logic hit_way;
    logic lru;
    logic dirty1;
    logic dirty2;
    // datapath array write enables
    logic load_tag1;
    logic load_tag2;
    logic load_valid1;
    logic load_valid2;
    logic load_data1;
    logic load_data2;
    logic load_dirty1;
    logic load_dirty2;
    logic load_lru;
    // datapath array write data and muxes
    logic valid1_in;
    logic valid2_in;
    logic dirty1_in;
    logic dirty2_in;
    logic lru_in;
    logic eviction;
    logic data_sel;
    logic pmem_addr_sel;
    // physical memory side
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    modport slave (
        input  mem_read, mem_write, hit, hit_way, lru, dirty1, dirty2, pmem_resp,
        output mem_resp,
        output load_tag1, load_tag2, load_valid1, load_valid2,
        output load_data1, load_data2, load_dirty1, load_dirty2, load_lru,
        output valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in,
        output eviction, data_sel, pmem_addr_sel, pmem_read, pmem_write
    );

    modport master (
        output mem_read, mem_write, hit, hit_way, lru, dirty1, dirty2, pmem_resp,
        input  mem_resp,
        input  load_tag1, load_tag2, load_valid1, load_valid2,
        input  load_data1, load_data2, load_dirty1, load_dirty2, load_lru,
        input  valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in,
        input  eviction, data_sel, pmem_addr_sel, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative write-back cache.
// A hit completes in the cycle it is presented. A miss evicts the LRU way.
// If the LRU way is dirty, the controller first writes it back
// (WRITEBACK), then refills it (FILL), then returns to CHECK. In CHECK the
// request is looked up again and now hits.
// Optional feature: define CACHE_PERF_COUNTERS_EN to build the access and
// miss counters. Without it, both counter outputs are tied to zero.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_if.slave       bus,
    output logic [CNT_WIDTH-1:0] access_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   req;
    logic   victim_dirty;
    logic   resp_evt;
    logic   miss_evt;

    // A read and a write together are served as a write.
    assign req          = bus.mem_read | bus.mem_write;
    assign victim_dirty = bus.lru ? bus.dirty2 : bus.dirty1;
    assign state_dbg    = state_q;

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_CHECK;
        else     state_q <= state_d;
    end

    // Next state and outputs; anything not driven by a state stays 0.
    always_comb begin
        state_d           = state_q;
        resp_evt          = 1'b0;
        miss_evt          = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.load_tag1     = 1'b0;
        bus.load_tag2     = 1'b0;
        bus.load_valid1   = 1'b0;
        bus.load_valid2   = 1'b0;
        bus.load_data1    = 1'b0;
        bus.load_data2    = 1'b0;
        bus.load_dirty1   = 1'b0;
        bus.load_dirty2   = 1'b0;
        bus.load_lru      = 1'b0;
        bus.valid1_in     = 1'b0;
        bus.valid2_in     = 1'b0;
        bus.dirty1_in     = 1'b0;
        bus.dirty2_in     = 1'b0;
        bus.lru_in        = 1'b0;
        bus.eviction      = 1'b0;
        bus.data_sel      = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        case (state_q)
            S_CHECK: begin
                if (req) begin
                    if (bus.hit) begin
                        // Hit: finish now and mark the other way as next victim.
                        resp_evt     = 1'b1;
                        bus.mem_resp = 1'b1;
                        bus.load_lru = 1'b1;
                        bus.lru_in   = ~bus.hit_way;
                        if (bus.mem_write) begin
                            bus.data_sel = 1'b1;
                            if (bus.hit_way) begin
                                bus.load_data2  = 1'b1;
                                bus.load_dirty2 = 1'b1;
                                bus.dirty2_in   = 1'b1;
                            end else begin
                                bus.load_data1  = 1'b1;
                                bus.load_dirty1 = 1'b1;
                                bus.dirty1_in   = 1'b1;
                            end
                        end
                    end else begin
                        miss_evt = 1'b1;
                        state_d  = victim_dirty ? S_WRITEBACK : S_FILL;
                    end
                end
            end
            S_WRITEBACK: begin
                // Victim tag + index addresses memory while the old line is written.
                bus.eviction      = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                bus.pmem_write    = 1'b1;
                if (bus.pmem_resp) state_d = S_FILL;
            end
            S_FILL: begin
                bus.eviction  = 1'b1;
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    // Install the fetched line clean and valid in the victim way.
                    if (bus.lru) begin
                        bus.load_data2  = 1'b1;
                        bus.load_tag2   = 1'b1;
                        bus.load_valid2 = 1'b1;
                        bus.load_dirty2 = 1'b1;
                        bus.valid2_in   = 1'b1;
                    end else begin
                        bus.load_data1  = 1'b1;
                        bus.load_tag1   = 1'b1;
                        bus.load_valid1 = 1'b1;
                        bus.load_dirty1 = 1'b1;
                        bus.valid1_in   = 1'b1;
                    end
                    state_d = S_CHECK;
                end
            end
            default: state_d = S_CHECK;
        endcase
    end

`ifdef CACHE_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] access_cnt_q, access_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    // Counters wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        access_cnt_d = access_cnt_q + {{(CNT_WIDTH-1){1'b0}}, resp_evt};
        miss_cnt_d   = miss_cnt_q + {{(CNT_WIDTH-1){1'b0}}, miss_evt};
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign access_count = access_cnt_q;
    assign miss_count   = miss_cnt_q;
`else
    logic unused_evt;
    assign unused_evt   = resp_evt ^ miss_evt;
    assign access_count = '0;
    assign miss_count   = '0;
`endif

endmodule
